// File: rtl/reg_share_arb.sv
// reg_share_arb: four requesters share one WIDTH-bit register through a
// round-robin arbiter. A grant writes the winner's data lane into q on the
// same edge that samples the request. The grant is held for one cycle, and
// the arbiter then waits for the owner to release its request.
// Optional feature macro: REG_SHARE_ARB_PARITY_EN adds q_par = ^q, which is
// registered on the same edge as q.
module reg_share_arb #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  syn_reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [1:0]            owner,
    output logic [WIDTH-1:0]      q,
    output logic                  q_valid,
`ifdef REG_SHARE_ARB_PARITY_EN
    output logic                  q_par,
`endif
    output logic                  busy
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_GRANT    = 2'd1;
    localparam logic [1:0] ST_WAIT_REL = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [1:0]       ptr_q,   ptr_d;
    logic [NREQ-1:0]  gnt_q,   gnt_d;
    logic [1:0]       owner_q, owner_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             valid_q, valid_d;

    logic             win_found;
    logic [1:0]       win_idx;
    logic [1:0]       scan_idx;

    // Rotating priority search: the first set request starting at ptr wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        scan_idx  = ptr_q;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = ptr_q + 2'(k);
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // Next-state logic for the FSM, the grant, the rotation pointer and the register.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        data_d  = data_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                if (win_found) begin
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    owner_d        = win_idx;
                    data_d         = wdata[win_idx*WIDTH +: WIDTH];
                    valid_d        = 1'b1;
                    state_d        = ST_GRANT;
                end
            end
            ST_GRANT: begin
                gnt_d   = '0;
                ptr_d   = owner_q + 2'd1;
                state_d = ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
                gnt_d = '0;
                if (!req[owner_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; a reset edge clears everything and performs no write.
    always_ff @(posedge clk) begin
        if (syn_reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            owner_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

`ifdef REG_SHARE_ARB_PARITY_EN
    logic par_q, par_d;

    // Parity follows the next register value, so it updates on the same edge as q.
    always_comb begin
        par_d = ^data_d;
    end

    // Parity register, cleared together with q.
    always_ff @(posedge clk) begin
        if (syn_reset) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign q_par = par_q;
`endif

    assign gnt     = gnt_q;
    assign owner   = owner_q;
    assign q       = data_q;
    assign q_valid = valid_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_reg_share_arb.sv
// Self-checking bench for reg_share_arb (WIDTH=8). Directed scenarios plus a
// randomized run, all checked against a behavioural arbitration model.
module tb_reg_share_arb;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          syn_reset = 1'b0;
    logic [3:0]    req = '0;
    logic [4*W-1:0] wdata = '0;
    logic [3:0]    gnt;
    logic [1:0]    owner;
    logic [W-1:0]  q;
    logic          q_valid;
    logic          busy;
`ifdef REG_SHARE_ARB_PARITY_EN
    logic          q_par;
`endif

    reg_share_arb #(.WIDTH(W), .NREQ(4)) dut (
        .clk      (clk),
        .syn_reset(syn_reset),
        .req      (req),
        .wdata    (wdata),
        .gnt      (gnt),
        .owner    (owner),
        .q        (q),
        .q_valid  (q_valid),
`ifdef REG_SHARE_ARB_PARITY_EN
        .q_par    (q_par),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural model.
    typedef enum {M_IDLE, M_GRANT, M_WAIT} mphase_t;
    mphase_t     m_ph   = M_IDLE;
    int          m_ptr  = 0;
    int          m_own  = 0;
    int          m_gnt  = 0;
    int          m_q    = 0;
    int          m_val  = 0;

    function automatic int lane_of(input logic [31:0] wd, input int i);
        return int'((wd >> (i * 8)) & 32'hFF);
    endfunction

    function automatic int parity8(input int v);
        int p = 0;
        for (int b = 0; b < 8; b++) p ^= (v >> b) & 1;
        return p;
    endfunction

    task automatic model_edge(input logic r, input logic [3:0] rq, input logic [31:0] wd);
        if (r) begin
            m_ph = M_IDLE; m_ptr = 0; m_own = 0; m_gnt = 0; m_q = 0; m_val = 0;
        end else begin
            case (m_ph)
                M_IDLE: begin
                    m_gnt = 0;
                    if (rq != 0) begin
                        for (int k = 0; k < 4; k++) begin
                            int cand = (m_ptr + k) % 4;
                            if (rq[cand] && m_gnt == 0) begin
                                m_gnt = 1 << cand;
                                m_own = cand;
                            end
                        end
                        m_q   = lane_of(wd, m_own);
                        m_val = 1;
                        m_ph  = M_GRANT;
                    end
                end
                M_GRANT: begin
                    m_gnt = 0;
                    m_ptr = (m_own + 1) % 4;
                    m_ph  = M_WAIT;
                end
                default: begin
                    m_gnt = 0;
                    if (!rq[m_own]) m_ph = M_IDLE;
                end
            endcase
        end
    endtask

    task automatic step(input logic r, input logic [3:0] rq, input logic [31:0] wd);
        syn_reset = r;
        req       = rq;
        wdata     = wd;
        @(posedge clk);
        model_edge(r, rq, wd);
        #1;
        check_eq("gnt",     32'(gnt),     32'(m_gnt));
        check_eq("owner",   32'(owner),   32'(m_own));
        check_eq("q",       32'(q),       32'(m_q));
        check_eq("q_valid", 32'(q_valid), 32'(m_val));
        check_eq("busy",    32'(busy),    32'(m_ph != M_IDLE));
`ifdef REG_SHARE_ARB_PARITY_EN
        check_eq("q_par",   32'(q_par),   32'(parity8(m_q)));
`endif
    endtask

    logic [31:0] lanes_seq = 32'h13121110;
    logic [3:0]  exp_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0]  exp_qseq  [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};

    initial begin
        int g;
        logic [3:0] rq;

        // Reset held two cycles with every request asserted.
        step(1'b1, 4'b1111, 32'hFFFFFFFF);
        step(1'b1, 4'b1111, 32'hFFFFFFFF);
        check_eq("rst_gnt",   32'(gnt),     32'h0);
        check_eq("rst_q",     32'(q),       32'h0);
        check_eq("rst_valid", 32'(q_valid), 32'h0);
        check_eq("rst_busy",  32'(busy),    32'h0);

        // Single write from requester 0.
        step(1'b0, 4'b0001, 32'h000000A5);
        check_eq("w0_gnt",   32'(gnt),     32'h1);
        check_eq("w0_q",     32'(q),       32'hA5);
        check_eq("w0_owner", 32'(owner),   32'h0);
        check_eq("w0_valid", 32'(q_valid), 32'h1);
        step(1'b0, 4'b0000, 32'h0);
        check_eq("w0_gnt_off", 32'(gnt), 32'h0);
        step(1'b0, 4'b0000, 32'h0);
        step(1'b0, 4'b0000, 32'h0);
        check_eq("w0_idle", 32'(busy), 32'h0);
        check_eq("w0_hold", 32'(q),    32'hA5);

        // Round-robin with all four requesting; the owner releases while busy.
        step(1'b1, 4'b0000, 32'h0);
        g = 0;
        for (int cyc = 0; cyc < 60 && g < 5; cyc++) begin
            rq = 4'b1111;
            if (m_ph != M_IDLE) rq[m_own] = 1'b0;
            step(1'b0, rq, lanes_seq);
            if (gnt != 0) begin
                check_eq("rr_order", 32'(gnt), 32'(exp_order[g]));
                check_eq("rr_q",     32'(q),   32'(exp_qseq[g]));
                g++;
            end
        end
        check_eq("rr_count", 32'(g), 32'd5);

        // Requester 2 holds its request; requester 0 waits, then wins via wrap.
        step(1'b1, 4'b0000, 32'h0);
        step(1'b0, 4'b0100, 32'h00330000);
        check_eq("hold_gnt2", 32'(gnt), 32'h4);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 4'b0101, 32'h00EE00EE);
            check_eq("hold_nognt", 32'(gnt), 32'h0);
            check_eq("hold_q",     32'(q),   32'h33);
        end
        step(1'b0, 4'b0001, 32'h000000C3);
        check_eq("hold_release_idle", 32'(busy), 32'h0);
        step(1'b0, 4'b0001, 32'h000000C3);
        check_eq("wrap_gnt0", 32'(gnt), 32'h1);
        check_eq("wrap_q",    32'(q),   32'hC3);

        // Reset arriving during GRANT.
        step(1'b0, 4'b0000, 32'h0);
        step(1'b0, 4'b0000, 32'h0);
        step(1'b0, 4'b1000, 32'h5A000000);
        check_eq("pre_rst_gnt", 32'(gnt), 32'h8);
        step(1'b1, 4'b1000, 32'h5A000000);
        check_eq("mid_rst_gnt",   32'(gnt),     32'h0);
        check_eq("mid_rst_q",     32'(q),       32'h0);
        check_eq("mid_rst_valid", 32'(q_valid), 32'h0);
        check_eq("mid_rst_busy",  32'(busy),    32'h0);

`ifdef REG_SHARE_ARB_PARITY_EN
        step(1'b0, 4'b0001, 32'h00000007);
        check_eq("par_07", 32'(q_par), 32'h1);
        step(1'b0, 4'b0000, 32'h0);
        step(1'b0, 4'b0000, 32'h0);
        step(1'b0, 4'b0001, 32'h00000003);
        check_eq("par_03", 32'(q_par), 32'h0);
`endif

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 59) == 0), 4'($urandom_range(0, 15)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
